// File: rtl/credit_pkg.sv
// rtl/credit_pkg.sv - shared types and sizing helpers for the credit receive path
package credit_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } rx_state_e;

   // Credit width shared with the sender's credit counter.
   localparam int CRED_BW = 4;

   function automatic int occ_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/credit_buf_fifo.sv
// rtl/credit_buf_fifo.sv - flit storage with wrap-at-DEPTH pointers and occupancy count
module credit_buf_fifo #(
   parameter int DW    = 8,
   parameter int DEPTH = 8,
   parameter int OW    = 4
) (
   input  logic          clk,
   input  logic          rst_b,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   output logic [OW-1:0] occupancy,
   output logic          full
);

   localparam int            PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] LAST   = PW'(DEPTH - 1);
   localparam logic [OW-1:0] FULL_O = OW'(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   // Storage is not reset; out_data is only meaningful while out_valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
      end else begin
         if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
         if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   occupancy <= occupancy + 1'b1;
            2'b01:   occupancy <= occupancy - 1'b1;
            default: occupancy <= occupancy;
         endcase
      end
   end

   assign out_valid = (occupancy != '0);
   assign full      = (occupancy == FULL_O);
   assign out_data  = mem[rd_ptr];

endmodule

// File: rtl/credit_rx_buf.sv
// rtl/credit_rx_buf.sv - credit-link receiver: link bring-up FSM, credit return and flit buffer
module credit_rx_buf
   import credit_pkg::*;
#(
   parameter int DW    = 8,
   parameter int DEPTH = 8,
   parameter int BW    = CRED_BW,
   localparam int OW   = occ_width(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_b,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          load_first_credits,
   output logic [BW-1:0] first_credits,
   output logic          credit_ret,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   input  logic          out_ready,
   output logic [OW-1:0] occupancy,
   output logic          link_up,
   output logic          proto_err
);

   localparam logic [OW-1:0] DEPTH_O = OW'(DEPTH);

   rx_state_e     state;
   rx_state_e     state_nxt;
   logic [OW-1:0] owed;
   logic          full;
   logic          pop;
   logic          push;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = LOAD;
         LOAD:    state_nxt = RUN;
         RUN:     state_nxt = RUN;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      load_first_credits = 1'b0;
      link_up            = 1'b0;
      credit_ret         = 1'b0;
      case (state)
         LOAD: load_first_credits = 1'b1;
         RUN: begin
            link_up    = 1'b1;
            credit_ret = (owed != '0);
         end
         default: ;
      endcase
   end

   assign first_credits = BW'(DEPTH);
   assign pop           = out_valid && out_ready;
   // A full buffer can still take a flit when the head leaves in the same cycle.
   assign push          = in_valid && link_up && (!full || pop);

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         owed      <= '0;
         proto_err <= 1'b0;
      end else begin
         if (state == LOAD)           owed <= DEPTH_O;
         else if (pop && !credit_ret) owed <= owed + 1'b1;
         else if (!pop && credit_ret) owed <= owed - 1'b1;
         if (in_valid && !push) proto_err <= 1'b1;
      end
   end

   credit_buf_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH),
      .OW    (OW)
   ) u_fifo (
      .clk       (clk),
      .rst_b     (rst_b),
      .push      (push),
      .push_data (in_data),
      .pop       (pop),
      .out_valid (out_valid),
      .out_data  (out_data),
      .occupancy (occupancy),
      .full      (full)
   );

endmodule
